mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between execute and writeback. Issues word-aligned
//  requests to the data memory with byte enables and lane-shifted store data.
//  Splits misaligned word and halfword accesses into two beats, stalling upstream.
//  Registers the control and address fields that writeback uses to mask or merge
//  load data. mem_rdata goes straight to writeback as its mem_result.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  BUBBLE_RST  1   bubble_out value at reset
// PORTS
//  clk          in   1   clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  clk_en       in   1   pipeline advance enable
//  halt         in   1   freeze: no state/output-register update, mem_req=0
//  flush        in   1   kill the in-flight instruction (exception/rfe in writeback)
//  bubble_in    in   1   execute slot is empty
//  opcode_in    in   5   3-5 word, 6-8 half, 9-11 byte memory ops
//  is_load_in / is_store_in   in  1 each
//  tgt_in_1 / tgt_in_2        in  5 each
//  addr_in      in   32  effective byte address
//  store_data   in   32  store value, right-justified
//  alu_in_1 / alu_in_2        in  32 each; pass-through results
//  exc_in       in   8   exception code; nonzero suppresses the memory access
//  stall_out    out  1   hold execute and earlier stages
//  mem_req      out  1   memory request valid
//  mem_we       out  1   write request
//  mem_addr     out  32  word address, bits[1:0]=0
//  mem_be       out  4   byte enables; bit i = byte lane i
//  mem_wdata    out  32  lane-aligned write data
//  mem_ready    in   1   request accepted this cycle; read data valid next cycle
//  bubble_out, is_load_out, is_store_out, is_misaligned_out   out  1 each (registered)
//  opcode_out 5, tgt_out_1/2 5, addr_out 32, alu_out_1/2 32, exc_out 8   out (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_NORM; bubble_out=BUBBLE_RST; all other
//    registered outputs 0; mem_req=0; stall_out=0.
//  - Offset and split rule: off=addr_in[1:0].
//    split = word op with off!=0, or half op with off==3. Bytes never split.
//  - Access gating: an access is needed when
//    !bubble_in && exc_in==0 && (is_load_in||is_store_in) && !flush.
//  - Request rule: mem_req = needed && clk_en && !halt.
//    The stage advances only when clk_en && !halt && (!mem_req || mem_ready).
//    When mem_req && !mem_ready: stall_out=1 and nothing updates.
//  - Non-split beat: mem_addr={addr[31:2],2'b00}.
//    Loads: mem_be=4'hF. Stores: be = byte 1<<off, half 3<<off, word 4'hF;
//    wdata = store_data<<(8*off).
//  - S_NORM with split: beat 1 goes to {addr[31:2],00}.
//    Store beat 1: be=(4'hF<<off)&4'hF for word, 4'b1000 for half;
//    wdata=store_data<<(8*off).
//    On advance: stall_out=1, bubble_out=1, addr_out=addr_in, go to S_SPLIT2.
//  - S_SPLIT2: beat 2 goes to {addr[31:2],00}+4 (wraps mod 2^32).
//    Store beat 2: be=4'hF>>(4-off) for word, 4'b0001 for half;
//    wdata=store_data>>(8*(4-off)).
//    On advance: register the real instruction with is_misaligned_out=1,
//    stall_out=0, return to S_NORM.
//  - Writeback merges beat-1 data, buffered the previous cycle, with beat-2 data.
//    Therefore addr_out must hold the original byte address on both beats.
//  - Normal advance copies all *_in fields to *_out, with is_misaligned_out=0.
//  - flush: highest priority on an enabled edge. bubble_out<=1, state<=S_NORM,
//    no request that cycle; a pending beat 2 is dropped.
//  - exc_in!=0: no request and no split; the instruction passes with exc_out=exc_in.
//  - Upstream inputs are stable in S_SPLIT2 because stall_out is held.
//  - Reset during S_SPLIT2 aborts the split immediately; no further request.
// STRUCTURE
//  - Shared package mem_pkg:
//    opcode range constants (OP_LW_LO=3 .. OP_LB_HI=11);
//    state encoding S_NORM/S_SPLIT2;
//    functions is_word/is_half/is_byte.
//  - One sub-module, mem_lane_gen (combinational): takes opcode, off and beat,
//    returns be and wdata.
//  - Top level holds the FSM, handshake and pipeline registers.
// TESTING
//  1. sw 0x11223344 @0x100, mem_ready=1 -> one req: addr 0x100, be F,
//     wdata 0x11223344; stall_out never 1.
//  2. lw @0x101 -> beat 1 addr 0x100 be F, bubble_out=1, stall_out=1.
//     Beat 2 addr 0x104; out: is_misaligned_out=1, addr_out=0x101.
//  3. sw 0xAABBCCDD @0x102 -> beat 1 be 4'b1100 wdata 0xCCDD0000;
//     beat 2 addr 0x104 be 4'b0011 wdata 0x0000AABB.
//  4. sb 0x5A @0x203 -> be 4'b1000, wdata 0x5A000000.
//     Then mem_ready=0 for 3 cycles -> stall_out=1, outputs frozen.
//  5. lw @0xFFFFFFFF -> beat 2 mem_addr 0x00000000.
//     flush in S_SPLIT2 -> no beat-2 req, bubble_out=1, state S_NORM.
//  6. exc_in=0x82 with lw -> mem_req=0, exc_out=0x82.
//     rst_n low mid-split -> bubble_out=1, mem_req=0 asynchronously.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: opcode ranges, FSM states and opcode-class helpers shared by the memory stage.
package mem_pkg;
  localparam logic [4:0] OP_LW_LO = 5'd3;
  localparam logic [4:0] OP_LW_HI = 5'd5;
  localparam logic [4:0] OP_LH_LO = 5'd6;
  localparam logic [4:0] OP_LH_HI = 5'd8;
  localparam logic [4:0] OP_LB_LO = 5'd9;
  localparam logic [4:0] OP_LB_HI = 5'd11;
  typedef enum logic {S_NORM, S_SPLIT2} state_t;
  function automatic logic is_word(input logic [4:0] op);
    return op >= OP_LW_LO && op <= OP_LW_HI;
  endfunction
  function automatic logic is_half(input logic [4:0] op);
    return op >= OP_LH_LO && op <= OP_LH_HI;
  endfunction
  function automatic logic is_byte(input logic [4:0] op);
    return op >= OP_LB_LO && op <= OP_LB_HI;
  endfunction
endpackage

// File: rtl/mem_lane_gen.sv
// mem_lane_gen: store byte enables and lane-shifted write data for the first or second beat.
module mem_lane_gen
  import mem_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [1:0]  i_off,
  input  logic        i_beat2,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);
  logic [2:0] w_sh2;
  logic [3:0] w_be1, w_be2;
  assign w_sh2 = 3'd4 - {1'b0, i_off};
  // Beat 1 covers the lanes from off upward; beat 2 the lanes that spilled past the word.
  always_comb begin
    w_be1   = is_word(i_opcode) ? 4'hF << i_off : is_half(i_opcode) ? 4'h3 << i_off : 4'h1 << i_off;
    w_be2   = is_word(i_opcode) ? 4'hF >> w_sh2 : is_half(i_opcode) ? 4'h1 : 4'h0;
    o_be    = i_beat2 ? w_be2 : w_be1;
    o_wdata = i_beat2 ? i_data >> {w_sh2, 3'b000} : i_data << {i_off, 3'b000};
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: issues data-memory requests, splits misaligned accesses into two beats, registers writeback fields.
module mem_stage
  import mem_pkg::*;
#(
  parameter int   ADDR_W     = 32,
  parameter logic BUBBLE_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              flush,
  input  logic              bubble_in,
  input  logic [4:0]        opcode_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [4:0]        tgt_in_1,
  input  logic [4:0]        tgt_in_2,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data,
  input  logic [31:0]       alu_in_1,
  input  logic [31:0]       alu_in_2,
  input  logic [7:0]        exc_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              bubble_out,
  output logic              is_load_out,
  output logic              is_store_out,
  output logic              is_misaligned_out,
  output logic [4:0]        opcode_out,
  output logic [4:0]        tgt_out_1,
  output logic [4:0]        tgt_out_2,
  output logic [ADDR_W-1:0] addr_out,
  output logic [31:0]       alu_out_1,
  output logic [31:0]       alu_out_2,
  output logic [7:0]        exc_out
);
  state_t r_state, w_next;
  logic r_bubble, r_ld, r_st, r_mis;
  logic [4:0] r_op, r_tgt1, r_tgt2;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_alu1, r_alu2;
  logic [7:0] r_exc;
  logic w_needed, w_split, w_beat2, w_adv;
  logic [1:0] w_off;
  logic [3:0] w_be;
  assign w_off   = addr_in[1:0];
  assign w_beat2 = r_state == S_SPLIT2;
  assign w_needed = !bubble_in && exc_in == 8'h0 && (is_load_in || is_store_in) && !flush;
  assign w_split = w_needed && ((is_word(opcode_in) && w_off != 2'd0) || (is_half(opcode_in) && w_off == 2'd3));
  assign w_adv = clk_en && !halt && (!mem_req || mem_ready);
  mem_lane_gen u_lane (
    .i_opcode(opcode_in),
    .i_off   (w_off),
    .i_beat2 (w_beat2),
    .i_data  (store_data),
    .o_be    (w_be),
    .o_wdata (mem_wdata)
  );
  // Reset gates the combinational handshake so an aborted split stops requesting at once.
  always_comb begin
    mem_req   = rst_n && w_needed && clk_en && !halt;
    mem_we    = mem_req && is_store_in;
    mem_addr  = {addr_in[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, w_beat2, 2'b00};
    mem_be    = is_store_in ? w_be : 4'hF;
    stall_out = rst_n && (w_beat2 ? !w_adv : (w_split || (mem_req && !mem_ready)));
    w_next    = !w_adv ? r_state : (!flush && !w_beat2 && w_split) ? S_SPLIT2 : S_NORM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_NORM;
    else r_state <= w_next;
  // Beat 1 of a split registers a bubble but keeps the byte address for the merge in writeback.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bubble <= BUBBLE_RST;
      {r_ld, r_st, r_mis, r_op, r_tgt1, r_tgt2, r_addr, r_alu1, r_alu2, r_exc} <= '0;
    end else if (w_adv) begin
      if (flush || (!w_beat2 && w_split)) begin
        r_bubble <= 1'b1;
        r_mis    <= 1'b0;
        if (!flush) r_addr <= addr_in;
      end else begin
        r_bubble <= bubble_in;
        r_mis    <= w_beat2;
        r_ld     <= is_load_in;
        r_st     <= is_store_in;
        r_op     <= opcode_in;
        r_tgt1   <= tgt_in_1;
        r_tgt2   <= tgt_in_2;
        r_addr   <= addr_in;
        r_alu1   <= alu_in_1;
        r_alu2   <= alu_in_2;
        r_exc    <= exc_in;
      end
    end
  assign bubble_out        = r_bubble;
  assign is_load_out       = r_ld;
  assign is_store_out      = r_st;
  assign is_misaligned_out = r_mis;
  assign opcode_out        = r_op;
  assign tgt_out_1         = r_tgt1;
  assign tgt_out_2         = r_tgt2;
  assign addr_out          = r_addr;
  assign alu_out_1         = r_alu1;
  assign alu_out_2         = r_alu2;
  assign exc_out           = r_exc;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for the memory stage request and pipeline behaviour.
module tb_mem_stage;
  logic clk, rst_n, clk_en, halt, flush, bubble_in, is_load_in, is_store_in, mem_ready;
  logic [4:0] opcode_in, tgt_in_1, tgt_in_2, opcode_out, tgt_out_1, tgt_out_2;
  logic [31:0] addr_in, store_data, alu_in_1, alu_in_2, mem_addr, mem_wdata, addr_out, alu_out_1, alu_out_2;
  logic [7:0] exc_in, exc_out;
  logic stall_out, mem_req, mem_we, bubble_out, is_load_out, is_store_out, is_misaligned_out;
  logic [3:0] mem_be;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;
  req_t sb[$];
  int total = 0;
  int bad = 0;
  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .flush(flush),
    .bubble_in(bubble_in), .opcode_in(opcode_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
    .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2), .addr_in(addr_in), .store_data(store_data),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .exc_in(exc_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .bubble_out(bubble_out), .is_load_out(is_load_out), .is_store_out(is_store_out),
    .is_misaligned_out(is_misaligned_out), .opcode_out(opcode_out), .tgt_out_1(tgt_out_1),
    .tgt_out_2(tgt_out_2), .addr_out(addr_out), .alu_out_1(alu_out_1), .alu_out_2(alu_out_2), .exc_out(exc_out)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic take(input string tag);
    req_t e;
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".queued"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".we"}, 32'(mem_we), 32'(e.we));
      chk({tag, ".addr"}, mem_addr, e.addr);
      chk({tag, ".be"}, 32'(mem_be), 32'(e.be));
      if (e.we) chk({tag, ".wdata"}, mem_wdata, e.wd);
    end
  endtask
  task automatic drv(input logic b, input logic [4:0] op, input logic ld, input logic st,
                     input logic [31:0] a, input logic [31:0] sd, input logic [7:0] e);
    bubble_in = b; opcode_in = op; is_load_in = ld; is_store_in = st;
    addr_in = a; store_data = sd; exc_in = e;
    tgt_in_1 = a[4:0]; tgt_in_2 = ~a[4:0]; alu_in_1 = sd ^ a; alu_in_2 = ~a;
  endtask
  initial begin
    rst_n = 0; clk_en = 1; halt = 0; flush = 0; mem_ready = 1;
    drv(1, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst.bubble", 32'(bubble_out), 32'd1);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    chk("rst.addr_out", addr_out, 32'd0);
    chk("rst.mis", 32'(is_misaligned_out), 32'd0);
    chk("rst.exc", 32'(exc_out), 32'd0);
    @(negedge clk) rst_n = 1;
    @(negedge clk) drv(0, 3, 0, 1, 32'h100, 32'h11223344, 0);
    sb.push_back('{1'b1, 32'h100, 4'hF, 32'h11223344});
    #1 take("t1"); chk("t1.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1;
    chk("t1.bubble", 32'(bubble_out), 32'd0);
    chk("t1.st_out", 32'(is_store_out), 32'd1);
    chk("t1.addr_out", addr_out, 32'h100);
    chk("t1.alu1", alu_out_1, 32'h11223244);
    chk("t1.stall_after", 32'(stall_out), 32'd0);
    @(negedge clk) drv(0, 4, 1, 0, 32'h101, 0, 0);
    sb.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
    #1 take("t2b1"); chk("t2b1.stall", 32'(stall_out), 32'd1);
    @(posedge clk) #1;
    chk("t2b1.bubble", 32'(bubble_out), 32'd1);
    chk("t2b1.addr_out", addr_out, 32'h101);
    @(negedge clk) sb.push_back('{1'b0, 32'h104, 4'hF, 32'h0});
    #1 take("t2b2"); chk("t2b2.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1;
    chk("t2.mis", 32'(is_misaligned_out), 32'd1);
    chk("t2.bubble", 32'(bubble_out), 32'd0);
    chk("t2.addr_out", addr_out, 32'h101);
    chk("t2.ld_out", 32'(is_load_out), 32'd1);
    chk("t2.op_out", 32'(opcode_out), 32'd4);
    @(negedge clk) drv(0, 5, 0, 1, 32'h102, 32'hAABBCCDD, 0);
    sb.push_back('{1'b1, 32'h100, 4'b1100, 32'hCCDD0000});
    #1 take("t3b1");
    @(negedge clk) sb.push_back('{1'b1, 32'h104, 4'b0011, 32'h0000AABB});
    #1 take("t3b2");
    @(posedge clk) #1 chk("t3.mis", 32'(is_misaligned_out), 32'd1);
    @(negedge clk) drv(0, 9, 0, 1, 32'h203, 32'h5A, 0);
    sb.push_back('{1'b1, 32'h200, 4'b1000, 32'h5A000000});
    #1 take("t4"); chk("t4.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1;
    chk("t4.addr_out", addr_out, 32'h203);
    chk("t4.mis", 32'(is_misaligned_out), 32'd0);
    @(negedge clk) drv(0, 6, 1, 0, 32'h210, 0, 0);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4w.stall", 32'(stall_out), 32'd1);
      chk("t4w.req", 32'(mem_req), 32'd1);
      @(posedge clk) #1;
      chk("t4w.addr_out", addr_out, 32'h203);
      chk("t4w.st_out", 32'(is_store_out), 32'd1);
      @(negedge clk);
    end
    mem_ready = 1;
    sb.push_back('{1'b0, 32'h210, 4'hF, 32'h0});
    #1 take("t4r");
    @(posedge clk) #1;
    chk("t4r.addr_out", addr_out, 32'h210);
    chk("t4r.op_out", 32'(opcode_out), 32'd6);
    @(negedge clk) drv(0, 3, 1, 0, 32'h220, 0, 0);
    halt = 1;
    #1 chk("halt.req", 32'(mem_req), 32'd0);
    @(posedge clk) #1 chk("halt.addr_out", addr_out, 32'h210);
    @(negedge clk) halt = 0;
    sb.push_back('{1'b0, 32'h220, 4'hF, 32'h0});
    #1 take("halt.go");
    @(posedge clk) #1 chk("halt.go.addr_out", addr_out, 32'h220);
    @(negedge clk) drv(0, 3, 1, 0, 32'hFFFFFFFF, 0, 0);
    sb.push_back('{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0});
    #1 take("t5b1");
    @(negedge clk) mem_ready = 0;
    sb.push_back('{1'b0, 32'h0, 4'hF, 32'h0});
    #1 take("t5b2");
    @(negedge clk) flush = 1; mem_ready = 1;
    #1 chk("t5f.req", 32'(mem_req), 32'd0);
    chk("t5f.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1 chk("t5f.bubble", 32'(bubble_out), 32'd1);
    chk("t5f.mis", 32'(is_misaligned_out), 32'd0);
    @(negedge clk) flush = 0;
    drv(0, 3, 0, 1, 32'h300, 32'h12345678, 0);
    sb.push_back('{1'b1, 32'h300, 4'hF, 32'h12345678});
    #1 take("t5n"); chk("t5n.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1 chk("t5n.bubble", 32'(bubble_out), 32'd0);
    @(negedge clk) drv(0, 3, 1, 0, 32'h400, 0, 8'h82);
    #1 chk("t6.req", 32'(mem_req), 32'd0);
    chk("t6.stall", 32'(stall_out), 32'd0);
    @(posedge clk) #1;
    chk("t6.exc_out", 32'(exc_out), 32'h82);
    chk("t6.bubble", 32'(bubble_out), 32'd0);
    chk("t6.addr_out", addr_out, 32'h400);
    @(negedge clk) drv(0, 3, 1, 0, 32'h501, 0, 0);
    sb.push_back('{1'b0, 32'h500, 4'hF, 32'h0});
    #1 take("t7b1");
    @(negedge clk) #1;
    chk("t7b2.req", 32'(mem_req), 32'd1);
    chk("t7b2.addr", mem_addr, 32'h504);
    #1 rst_n = 0;
    #1 chk("t7r.bubble", 32'(bubble_out), 32'd1);
    chk("t7r.req", 32'(mem_req), 32'd0);
    chk("t7r.stall", 32'(stall_out), 32'd0);
    chk("t7r.addr_out", addr_out, 32'd0);
    @(negedge clk) rst_n = 1;
    drv(1, 0, 0, 0, 0, 0, 0);
    #1 chk("t7p.req", 32'(mem_req), 32'd0);
    @(posedge clk) #1 chk("t7p.bubble", 32'(bubble_out), 32'd1);
    chk("end.queue", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
